// File: rtl/wb_dma_copy.sv
// ---------------------------------------------------------------------------
// wb_dma_copy
//
// Memory-to-memory copy engine. Software programs a source address, a
// destination address and a word count through the CSR bus and then sets
// start. The engine moves the words one at a time as a Wishbone master. Each
// word is a classic single read followed by a classic single write. The bus is
// left idle for one clock between cycles. A level interrupt reports completion.
//
// Ports
//   sys_clk    : system clock; all logic is rising-edge
//   sys_rst_n  : synchronous reset, active-low
//   csr_a      : CSR address; [13:10] block select, [2:0] register index
//   csr_we     : CSR write strobe
//   csr_di     : CSR write data
//   csr_do     : CSR read data; registered, valid one cycle after csr_a;
//                0 when this block is not selected
//   irq        : level interrupt, registered copy of done & irq_en
//   wb_adr_o   : Wishbone byte address (word aligned)
//   wb_dat_o   : Wishbone write data
//   wb_dat_i   : Wishbone read data
//   wb_sel_o   : byte selects, always all four lanes
//   wb_cti_o   : cycle type, always classic
//   wb_we_o    : write enable
//   wb_cyc_o   : cycle
//   wb_stb_o   : strobe (identical to cyc)
//   wb_ack_i   : acknowledge
//
// Register map (csr_a[2:0])
//   0 SRC    rw  source byte address, bits [1:0] read as 0
//   1 DST    rw  destination byte address, bits [1:0] read as 0
//   2 LEN    rw  word count
//   3 CTRL   rw  write: b0 start, b1 irq_en, b2 clear done/aborted, b3 abort
//                read : b0 busy,  b1 irq_en, b2 done,               b3 aborted
//   4 REMAIN ro  words still to copy
// ---------------------------------------------------------------------------
module wb_dma_copy #(
    parameter logic [3:0] csr_addr  = 4'h4,
    parameter int         LEN_WIDTH = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [13:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    output logic        irq,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic [2:0]  wb_cti_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [31:0]            src_reg;
    logic [31:0]            dst_reg;
    logic [LEN_WIDTH-1:0]   len_reg;
    logic [LEN_WIDTH-1:0]   remain_reg;
    logic [31:0]            data_reg;
    logic [31:0]            adr_reg;
    logic                   cyc_reg;
    logic                   we_reg;
    logic                   irq_en_reg;
    logic                   done_reg;
    logic                   aborted_reg;
    logic                   abort_pend_reg;
    logic                   irq_reg;
    logic [31:0]            csr_do_reg;

    logic [31:0]            csr_rd_next;
    logic [31:0]            src_next;
    logic [31:0]            dst_next;
    logic [LEN_WIDTH-1:0]   remain_next;

    logic                   csr_sel;
    logic [7:0]             reg_wr;
    logic                   busy;
    logic                   ctrl_start;
    logic                   ctrl_clear;
    logic                   ctrl_abort;
    logic                   abort_req;
    logic                   last_word;

    // Address bits between the block select and the register index carry no
    // meaning for this block.
    logic                   unused_addr_bits;
    assign unused_addr_bits = &{1'b0, csr_a[9:3]};

    assign csr_sel = (csr_a[13:10] == csr_addr);

    // One write strobe per register index.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_reg_wr
            assign reg_wr[gi] = csr_sel & csr_we & (csr_a[2:0] == 3'(gi));
        end
    endgenerate

    assign busy       = (state_reg != IDLE);
    assign ctrl_start = reg_wr[3] & csr_di[0];
    assign ctrl_clear = reg_wr[3] & csr_di[2];
    assign ctrl_abort = reg_wr[3] & csr_di[3];

    // An abort written in the same cycle as an ack is honoured at that ack,
    // just like one that was already pending.
    assign abort_req  = abort_pend_reg | ctrl_abort;
    assign last_word  = (remain_reg == LEN_WIDTH'(1));

    assign src_next    = src_reg + 32'd4;
    assign dst_next    = dst_reg + 32'd4;
    assign remain_next = remain_reg - LEN_WIDTH'(1);

    // CSR read mux; the result is registered below so csr_do lags csr_a by
    // one clock.
    always_comb begin
        csr_rd_next = '0;
        case (csr_a[2:0])
            3'd0:    csr_rd_next = src_reg;
            3'd1:    csr_rd_next = dst_reg;
            3'd2:    csr_rd_next = 32'(len_reg);
            3'd3:    csr_rd_next = {28'd0, aborted_reg, done_reg, irq_en_reg, busy};
            3'd4:    csr_rd_next = 32'(remain_reg);
            default: csr_rd_next = '0;
        endcase
    end

    // Control FSM, configuration registers and all bus outputs.
    // While a transfer runs, cyc_reg separates the two halves of a state:
    // cyc low is the mandatory idle clock before the next bus cycle; cyc high
    // means a cycle is in flight and waiting for its ack.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_reg      <= IDLE;
            src_reg        <= '0;
            dst_reg        <= '0;
            len_reg        <= '0;
            remain_reg     <= '0;
            data_reg       <= '0;
            adr_reg        <= '0;
            cyc_reg        <= 1'b0;
            we_reg         <= 1'b0;
            irq_en_reg     <= 1'b0;
            done_reg       <= 1'b0;
            aborted_reg    <= 1'b0;
            abort_pend_reg <= 1'b0;
            irq_reg        <= 1'b0;
            csr_do_reg     <= '0;
        end else begin
            // Transfer parameters are frozen while a copy is running.
            if (!busy) begin
                if (reg_wr[0]) src_reg <= {csr_di[31:2], 2'b00};
                if (reg_wr[1]) dst_reg <= {csr_di[31:2], 2'b00};
                if (reg_wr[2]) len_reg <= csr_di[LEN_WIDTH-1:0];
            end
            if (reg_wr[3]) irq_en_reg <= csr_di[1];
            if (ctrl_clear) begin
                done_reg    <= 1'b0;
                aborted_reg <= 1'b0;
            end
            if (busy && ctrl_abort) abort_pend_reg <= 1'b1;

            // Assignments below come after the CSR side so that completion and
            // start take priority over a clear written in the same cycle.
            case (state_reg)
                IDLE: begin
                    if (ctrl_start) begin
                        done_reg    <= 1'b0;
                        aborted_reg <= 1'b0;
                        if (len_reg != '0) begin
                            remain_reg <= len_reg;
                            state_reg  <= READ;
                        end else begin
                            done_reg <= 1'b1;
                        end
                    end
                end

                READ: begin
                    if (!cyc_reg) begin
                        if (abort_req) begin
                            state_reg      <= IDLE;
                            done_reg       <= 1'b1;
                            aborted_reg    <= 1'b1;
                            abort_pend_reg <= 1'b0;
                        end else begin
                            cyc_reg <= 1'b1;
                            we_reg  <= 1'b0;
                            adr_reg <= src_reg;
                        end
                    end else if (wb_ack_i) begin
                        data_reg <= wb_dat_i;
                        cyc_reg  <= 1'b0;
                        if (abort_req) begin
                            // Word was fetched but is dropped; remain keeps it.
                            state_reg      <= IDLE;
                            done_reg       <= 1'b1;
                            aborted_reg    <= 1'b1;
                            abort_pend_reg <= 1'b0;
                        end else begin
                            state_reg <= WRITE;
                        end
                    end
                end

                WRITE: begin
                    if (!cyc_reg) begin
                        if (abort_req) begin
                            state_reg      <= IDLE;
                            done_reg       <= 1'b1;
                            aborted_reg    <= 1'b1;
                            abort_pend_reg <= 1'b0;
                        end else begin
                            cyc_reg <= 1'b1;
                            we_reg  <= 1'b1;
                            adr_reg <= dst_reg;
                        end
                    end else if (wb_ack_i) begin
                        cyc_reg    <= 1'b0;
                        we_reg     <= 1'b0;
                        src_reg    <= src_next;
                        dst_reg    <= dst_next;
                        remain_reg <= remain_next;
                        if (last_word) begin
                            // The final word wins over a late abort.
                            state_reg      <= IDLE;
                            done_reg       <= 1'b1;
                            aborted_reg    <= 1'b0;
                            abort_pend_reg <= 1'b0;
                        end else if (abort_req) begin
                            state_reg      <= IDLE;
                            done_reg       <= 1'b1;
                            aborted_reg    <= 1'b1;
                            abort_pend_reg <= 1'b0;
                        end else begin
                            state_reg <= READ;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    cyc_reg   <= 1'b0;
                    we_reg    <= 1'b0;
                end
            endcase

            irq_reg    <= done_reg & irq_en_reg;
            csr_do_reg <= csr_sel ? csr_rd_next : '0;
        end
    end

    assign csr_do   = csr_do_reg;
    assign irq      = irq_reg;
    assign wb_adr_o = adr_reg;
    assign wb_dat_o = data_reg;
    assign wb_sel_o = 4'hf;
    assign wb_cti_o = 3'b000;
    assign wb_we_o  = we_reg;
    assign wb_cyc_o = cyc_reg;
    assign wb_stb_o = cyc_reg;

endmodule

// File: tb/tb_wb_dma_copy.sv
// ---------------------------------------------------------------------------
// tb_wb_dma_copy
//
// Bench for wb_dma_copy. A Wishbone slave with a programmable number of wait
// states serves a sparse memory. Unwritten words read as a fixed pattern of
// their address. Each copy is modelled as an expected list of bus
// transactions: read src+4i, then write dst+4i with the pattern of src+4i. The
// bus process compares every active bus cycle against the head of that list.
// Directed CSR sequences cover reset, length zero, address wrap, abort,
// writes while busy and reset mid-transfer.
// ---------------------------------------------------------------------------
module tb_wb_dma_copy;

    localparam logic [3:0] BLK = 4'h4;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;
    logic        irq;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;

    wb_dma_copy #(.csr_addr(BLK), .LEN_WIDTH(16)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .csr_a     (csr_a),
        .csr_we    (csr_we),
        .csr_di    (csr_di),
        .csr_do    (csr_do),
        .irq       (irq),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_o  (wb_sel_o),
        .wb_cti_o  (wb_cti_o),
        .wb_we_o   (wb_we_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_ack_i  (wb_ack_i)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] obs_rd[$];
    logic [31:0] obs_wr[$];
    logic [31:0] mem [logic [31:0]];
    int          wait_cycles = 1;
    int          n_txn       = 0;
    int          pass_cnt    = 0;
    int          total_cnt   = 0;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return pat(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    endtask

    task automatic expect_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{1'b0, s + 32'(4 * i), 32'h0});
            exp_q.push_back('{1'b1, d + 32'(4 * i), pat(s + 32'(4 * i))});
        end
    endtask

    // Slave plus bus checker. Everything is sampled on the falling edge.
    initial begin
        int   wcnt;
        txn_t e;
        wb_ack_i = 1'b0;
        wb_dat_i = '0;
        wcnt     = 0;
        forever begin
            @(negedge sys_clk);
            if (wb_ack_i) begin
                // Handshake completed at the edge just passed: bus must rest.
                check("bus_gap_cyc", 32'(wb_cyc_o), 32'd0);
                wb_ack_i = 1'b0;
                wcnt     = 0;
            end else if (wb_cyc_o && wb_stb_o) begin
                check("bus_sel", 32'(wb_sel_o), 32'hf);
                check("bus_cti", 32'(wb_cti_o), 32'h0);
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL bus_unexpected: got we=%0d adr=0x%08h required no bus cycle",
                             wb_we_o, wb_adr_o);
                    wb_ack_i = 1'b1;
                end else begin
                    e = exp_q[0];
                    check("bus_we", 32'(wb_we_o), 32'(e.we));
                    check("bus_adr", wb_adr_o, e.adr);
                    if (e.we) check("bus_dat", wb_dat_o, e.dat);
                    if (wcnt >= wait_cycles) begin
                        wb_ack_i = 1'b1;
                        if (wb_we_o) begin
                            mem[wb_adr_o] = wb_dat_o;
                            obs_wr.push_back(wb_adr_o);
                            $display("txn W adr=0x%08h dat=0x%08h", wb_adr_o, wb_dat_o);
                        end else begin
                            wb_dat_i = rd_word(wb_adr_o);
                            obs_rd.push_back(wb_adr_o);
                            $display("txn R adr=0x%08h dat=0x%08h", wb_adr_o, wb_dat_i);
                        end
                        void'(exp_q.pop_front());
                        n_txn++;
                    end else begin
                        wcnt++;
                    end
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic csr_write(input logic [2:0] idx, input logic [31:0] d);
        @(negedge sys_clk);
        csr_a  = {BLK, 7'd0, idx};
        csr_di = d;
        csr_we = 1'b1;
        @(negedge sys_clk);
        csr_we = 1'b0;
        csr_a  = {4'hF, 10'd0};
    endtask

    task automatic csr_read_blk(input logic [3:0] blk, input logic [2:0] idx, output logic [31:0] d);
        @(negedge sys_clk);
        csr_a = {blk, 7'd0, idx};
        @(negedge sys_clk);
        d     = csr_do;
        csr_a = {4'hF, 10'd0};
    endtask

    task automatic csr_check(input string name, input logic [2:0] idx, input logic [31:0] exp);
        logic [31:0] v;
        csr_read_blk(BLK, idx, v);
        check(name, v, exp);
    endtask

    task automatic wait_idle();
        logic [31:0] v;
        v = 32'h1;
        for (int i = 0; i < 3000 && v[0]; i++) csr_read_blk(BLK, 3'd3, v);
        check("wait_idle_busy", 32'(v[0]), 32'd0);
    endtask

    task automatic wait_cyc(input logic want_we);
        for (int i = 0; i < 200 && !(wb_cyc_o && wb_we_o == want_we); i++) @(negedge sys_clk);
        check("wait_cyc", 32'(wb_cyc_o && wb_we_o == want_we), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst_n = 1'b0;
        csr_a     = {4'hF, 10'd0};
        csr_we    = 1'b0;
        csr_di    = '0;
        repeat (3) @(negedge sys_clk);

        // Reset state.
        check("rst_csr_do", csr_do, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_cyc", 32'(wb_cyc_o), 32'h0);
        check("rst_stb", 32'(wb_stb_o), 32'h0);
        check("rst_we", 32'(wb_we_o), 32'h0);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) csr_check("rst_reg", 3'(i), 32'h0);

        // Four-word copy, one wait state.
        wait_cycles = 1;
        n_txn = 0;
        obs_rd.delete();
        obs_wr.delete();
        csr_write(3'd0, 32'h0000_0103);   // low bits must be dropped
        csr_write(3'd1, 32'h0000_0200);
        csr_write(3'd2, 32'd4);
        csr_check("src_readback", 3'd0, 32'h100);
        expect_copy(32'h100, 32'h200, 4);
        csr_write(3'd3, 32'h1);
        wait_idle();
        check("copy4_ctrl", 0, 0);
        csr_check("copy4_ctrl_rd", 3'd3, 32'h4);
        csr_check("copy4_remain", 3'd4, 32'h0);
        check("copy4_left", 32'(exp_q.size()), 32'd0);
        check("copy4_ntxn", 32'(n_txn), 32'd8);
        check("copy4_rd0", obs_rd[0], 32'h100);
        check("copy4_wr0", obs_wr[0], 32'h200);
        check("copy4_rd3", obs_rd[3], 32'h10C);
        check("copy4_wr3", obs_wr[3], 32'h20C);
        for (int i = 0; i < 4; i++)
            check("copy4_dst_eq_src", rd_word(32'h200 + 32'(4 * i)), rd_word(32'h100 + 32'(4 * i)));

        // Zero length: done next cycle, no bus activity, irq a cycle later.
        csr_write(3'd3, 32'h4);
        csr_check("len0_cleared", 3'd3, 32'h0);
        csr_write(3'd2, 32'd0);
        csr_write(3'd3, 32'h3);
        check("len0_irq_lag", 32'(irq), 32'd0);
        @(negedge sys_clk);
        check("len0_irq", 32'(irq), 32'd1);
        csr_check("len0_ctrl", 3'd3, 32'h6);
        csr_write(3'd3, 32'h4);
        repeat (2) @(negedge sys_clk);
        check("len0_irq_off", 32'(irq), 32'd0);

        // Source address wraps through zero.
        obs_rd.delete();
        csr_write(3'd0, 32'hFFFF_FFF8);
        csr_write(3'd1, 32'h0000_0300);
        csr_write(3'd2, 32'd3);
        expect_copy(32'hFFFF_FFF8, 32'h300, 3);
        csr_write(3'd3, 32'h1);
        wait_idle();
        check("wrap_rd0", obs_rd[0], 32'hFFFF_FFF8);
        check("wrap_rd1", obs_rd[1], 32'hFFFF_FFFC);
        check("wrap_rd2", obs_rd[2], 32'h0000_0000);
        csr_check("wrap_src_end", 3'd0, 32'h4);
        check("wrap_left", 32'(exp_q.size()), 32'd0);

        // Abort during a stalled read: read finishes, nothing is written.
        wait_cycles = 20;
        csr_write(3'd0, 32'h1000);
        csr_write(3'd1, 32'h2000);
        csr_write(3'd2, 32'd100);
        exp_q.push_back('{1'b0, 32'h1000, 32'h0});
        csr_write(3'd3, 32'h1);
        wait_cyc(1'b0);
        repeat (3) @(negedge sys_clk);
        csr_write(3'd3, 32'h8);
        wait_idle();
        csr_check("abort_ctrl", 3'd3, 32'hC);
        csr_check("abort_remain", 3'd4, 32'd100);
        csr_check("abort_src", 3'd0, 32'h1000);
        check("abort_left", 32'(exp_q.size()), 32'd0);
        check("abort_no_write", 32'(mem.exists(32'h2000)), 32'd0);

        // Writes while busy are ignored except irq_en/abort.
        wait_cycles = 1;
        csr_write(3'd0, 32'h400);
        csr_write(3'd1, 32'h500);
        csr_write(3'd2, 32'd3);
        expect_copy(32'h400, 32'h500, 3);
        csr_write(3'd3, 32'h1);
        csr_write(3'd0, 32'hDEAD_0000);
        csr_write(3'd3, 32'h1);
        csr_write(3'd2, 32'd9);
        csr_check("busy_ctrl", 3'd3, 32'h1);
        wait_idle();
        csr_check("busy_src_end", 3'd0, 32'h40C);
        csr_check("busy_dst_end", 3'd1, 32'h50C);
        csr_check("busy_len", 3'd2, 32'd3);
        csr_check("busy_remain", 3'd4, 32'd0);
        csr_check("busy_done", 3'd3, 32'h4);
        check("busy_left", 32'(exp_q.size()), 32'd0);
        begin
            logic [31:0] v;
            csr_read_blk(4'h3, 3'd0, v);
            check("other_block_rd", v, 32'h0);
        end

        // Reset in the middle of a stalled write.
        wait_cycles = 30;
        csr_write(3'd0, 32'h600);
        csr_write(3'd1, 32'h700);
        csr_write(3'd2, 32'd2);
        expect_copy(32'h600, 32'h700, 2);
        csr_write(3'd3, 32'h3);
        wait_cyc(1'b1);
        csr_a = {BLK, 7'd0, 3'd3};
        @(negedge sys_clk);
        check("pre_rst_csr_do", csr_do, 32'h3);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("mid_rst_cyc", 32'(wb_cyc_o), 32'd0);
        check("mid_rst_stb", 32'(wb_stb_o), 32'd0);
        check("mid_rst_we", 32'(wb_we_o), 32'd0);
        check("mid_rst_irq", 32'(irq), 32'd0);
        check("mid_rst_csr_do", csr_do, 32'h0);
        exp_q.delete();
        csr_a = {4'hF, 10'd0};
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) csr_check("mid_rst_reg", 3'(i), 32'h0);
        check("mid_rst_no_write", 32'(mem.exists(32'h700)), 32'd0);
        repeat (5) @(negedge sys_clk);
        check("mid_rst_idle_bus", 32'(wb_cyc_o), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
